// File: rtl/dpf_trace_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dpf_trace_gen                                                 |
// | Purpose  : Emits (current, next) state pairs of the dynamic-partition    |
// |            fixpoint transition system on a valid/ready stream.           |
// |            Optional macro DPF_TRACE_GEN_INIT_CHECK_EN: accept start only |
// |            from the all-zero initial state and pulse err otherwise.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dpf_trace_gen #(
  parameter int CNT_W = 3,
  parameter int STEPS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     init_a,
  input  logic [CNT_W-1:0]     init_b,
  input  logic [1:0]           init_ph,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*CNT_W+1:0]   out_state,
  output logic [2*CNT_W+1:0]   out_next,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [15:0] C_LAST_STEP = 16'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  a_q, a_d;
  logic [CNT_W-1:0]  b_q, b_d;
  logic [1:0]        ph_q, ph_d;
  logic [15:0]       step_q, step_d;

  logic              w_mode;
  logic [CNT_W-1:0]  w_a_nxt;
  logic [CNT_W-1:0]  w_b_nxt;
  logic [1:0]        w_ph_nxt;
  logic              w_init_ok;
  logic              w_handshake;

`ifdef DPF_TRACE_GEN_INIT_CHECK_EN
  // Only the all-zero initial state is a legal antecedent for the checker.
  assign w_init_ok = (init_a == '0) && (init_b == '0) && (init_ph == 2'b00);
`else
  assign w_init_ok = 1'b1;
`endif

  // Successor of the registered state; phase is a 2-bit Johnson counter.
  always_comb begin
    w_mode   = ph_q[1] ^ ph_q[0];
    w_a_nxt  = a_q;
    w_b_nxt  = b_q;
    if (w_mode) begin
      w_b_nxt = b_q + 1'b1;
    end else begin
      w_a_nxt = a_q + 1'b1;
    end
    w_ph_nxt = {ph_q[0], ~ph_q[1]};
  end

  assign out_state   = {ph_q, b_q, a_q};
  assign out_next    = {w_ph_nxt, w_b_nxt, w_a_nxt};
  assign out_valid   = (state_q == S_EMIT);
  assign busy        = (state_q == S_EMIT);
  assign done        = (state_q == S_DONE);
  assign w_handshake = out_valid & out_ready;

  // Next-state logic: run control, state loading and stepping.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ph_d    = ph_q;
    step_d  = step_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && w_init_ok) begin
          a_d     = init_a;
          b_d     = init_b;
          ph_d    = init_ph;
          step_d  = 16'd0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_handshake) begin
          a_d    = w_a_nxt;
          b_d    = w_b_nxt;
          ph_d   = w_ph_nxt;
          step_d = step_q + 16'd1;
          if (step_q == C_LAST_STEP) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset clears the trace state so out_next shows (1,0,01).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ph_q    <= 2'b00;
      step_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ph_q    <= ph_d;
      step_q  <= step_d;
    end
  end

`ifdef DPF_TRACE_GEN_INIT_CHECK_EN
  logic err_q;

  // One-cycle pulse after a start that was refused for a non-zero init.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state_q == S_IDLE) && start && !w_init_ok;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dpf_trace_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dpf_trace_gen                                              |
// | Purpose  : Self-checking bench for dpf_trace_gen (STEPS=4 and STEPS=1).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dpf_trace_gen;

  localparam int CW  = 3;
  localparam int SW  = 2*CW + 2;
  localparam int MOD = 1 << CW;
  localparam int NST = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] init_a = '0;
  logic [CW-1:0] init_b = '0;
  logic [1:0]    init_ph = 2'b00;
  logic          out_ready = 1'b1;

  logic          v4, b4, d4, e4;
  logic [SW-1:0] s4, n4;
  logic          v1, b1, d1, e1;
  logic [SW-1:0] s1, n1;

  int checks = 0;
  int errors = 0;

  // Phase visiting order; modes alternate 0,1,0,1 along it.
  int ph_seq [4] = '{0, 1, 3, 2};

  always #5 clk = ~clk;

  dpf_trace_gen #(.CNT_W(CW), .STEPS(NST)) dut4 (
    .clk(clk), .rst(rst), .start(start),
    .init_a(init_a), .init_b(init_b), .init_ph(init_ph),
    .out_valid(v4), .out_ready(out_ready),
    .out_state(s4), .out_next(n4),
    .busy(b4), .done(d4), .err(e4)
  );

  dpf_trace_gen #(.CNT_W(CW), .STEPS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .init_a(init_a), .init_b(init_b), .init_ph(init_ph),
    .out_valid(v1), .out_ready(out_ready),
    .out_state(s1), .out_next(n1),
    .busy(b1), .done(d1), .err(e1)
  );

  function automatic logic [SW-1:0] pack(input int a, input int b, input int p);
    return {2'(p), CW'(b), CW'(a)};
  endfunction

  // Reference successor: locate phase in the cycle, even slot bumps A, odd bumps B.
  task automatic succ(input int a, input int b, input int p,
                      output int na, output int nb, output int np);
    int idx;
    idx = 0;
    for (int k = 0; k < 4; k++) if (ph_seq[k] == p) idx = k;
    na = a; nb = b;
    if (idx % 2 == 0) na = (a + 1) % MOD;
    else              nb = (b + 1) % MOD;
    np = ph_seq[(idx + 1) % 4];
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({v4, b4, d4, e4, v1, b1, d1, e1} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000000", {v4, b4, d4, e4, v1, b1, d1, e1});
    end
    checks++;
    if (s4 !== '0) begin
      errors++; $display("FAIL reset_state: got %h required 00", s4);
    end
    checks++;
    if (n4 !== pack(1, 0, 1)) begin
      errors++; $display("FAIL reset_next: got %h required %h", n4, pack(1, 0, 1));
    end
    rst = 1'b0;
    tick();
  endtask

  // Runs a STEPS=4 trace from (a0,b0,p0) with ready held high, against fixed expectations.
  task automatic test_fixed_trace(input string nm, input int a0, input int b0, input int p0,
                                  input logic [SW-1:0] exp [5]);
    init_a = CW'(a0); init_b = CW'(b0); init_ph = 2'(p0);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < NST; i++) begin
      checks++;
      if (v4 !== 1'b1 || b4 !== 1'b1 || d4 !== 1'b0) begin
        errors++; $display("FAIL %s_ctrl beat %0d: valid/busy/done=%b%b%b required 110", nm, i, v4, b4, d4);
      end
      checks++;
      if (s4 !== exp[i] || n4 !== exp[i+1]) begin
        errors++;
        $display("FAIL %s_pair beat %0d: got %h->%h required %h->%h", nm, i, s4, n4, exp[i], exp[i+1]);
      end
      tick();
    end
    checks++;
    if (d4 !== 1'b1 || v4 !== 1'b0 || s4 !== exp[4]) begin
      errors++; $display("FAIL %s_done: done=%b valid=%b state=%h required 1 0 %h", nm, d4, v4, s4, exp[4]);
    end
    tick();
    checks++;
    if (d4 !== 1'b0) begin
      errors++; $display("FAIL %s_done_len: done=%b required 0", nm, d4);
    end
    repeat (2) tick();
  endtask

  task automatic test_basic;
    logic [SW-1:0] exp [5];
    exp = '{pack(0,0,0), pack(1,0,1), pack(1,1,3), pack(2,1,2), pack(2,2,0)};
    test_fixed_trace("basic", 0, 0, 0, exp);
  endtask

  task automatic test_wrap;
    logic [SW-1:0] exp [5];
    exp = '{pack(7,7,0), pack(0,7,1), pack(0,0,3), pack(1,0,2), pack(1,1,0)};
    test_fixed_trace("wrap", 7, 7, 0, exp);
  endtask

  // mode 0: random ready; mode 1: ready pattern 1,0,0,1,...; mode 2: start poked during EMIT.
  task automatic test_random_stream(input int mode, input int runs);
    int a, b, p, na, nb, np, hs, cyc;
    bit rdy;
    for (int r = 0; r < runs; r++) begin
`ifdef DPF_TRACE_GEN_INIT_CHECK_EN
      a = 0; b = 0; p = 0;
`else
      a = $urandom_range(MOD - 1); b = $urandom_range(MOD - 1); p = $urandom_range(3);
`endif
      init_a = CW'(a); init_b = CW'(b); init_ph = 2'(p);
      start = 1'b1;
      tick();
      start = 1'b0;
      hs = 0; cyc = 0;
      while (hs < NST && cyc < 200) begin
        succ(a, b, p, na, nb, np);
        checks++;
        if (v4 !== 1'b1 || b4 !== 1'b1 || d4 !== 1'b0 || e4 !== 1'b0) begin
          errors++;
          $display("FAIL stream%0d_ctrl cyc %0d: valid/busy/done/err=%b%b%b%b required 1100", mode, cyc, v4, b4, d4, e4);
        end
        checks++;
        if (s4 !== pack(a, b, p) || n4 !== pack(na, nb, np)) begin
          errors++;
          $display("FAIL stream%0d_pair cyc %0d: got %h->%h required %h->%h", mode, cyc, s4, n4,
                   pack(a, b, p), pack(na, nb, np));
        end
        case (mode)
          1:       rdy = !(cyc == 1 || cyc == 2);
          2:       rdy = 1'b1;
          default: rdy = 1'($urandom_range(1));
        endcase
        if (mode == 2) begin
          start = 1'b1;
          init_a = CW'($urandom); init_b = CW'($urandom); init_ph = 2'($urandom);
        end
        out_ready = rdy;
        tick();
        start = 1'b0;
        if (rdy) begin
          hs++; a = na; b = nb; p = np;
        end
        cyc++;
      end
      checks++;
      if (hs != NST) begin
        errors++; $display("FAIL stream%0d_timeout: handshakes %0d required %0d", mode, hs, NST);
      end
      checks++;
      if (d4 !== 1'b1 || v4 !== 1'b0 || b4 !== 1'b0 || s4 !== pack(a, b, p)) begin
        errors++;
        $display("FAIL stream%0d_done: done=%b valid=%b busy=%b state=%h required 1 0 0 %h",
                 mode, d4, v4, b4, s4, pack(a, b, p));
      end
      if (mode == 1) begin
        checks++;
        if (cyc != NST + 2) begin
          errors++; $display("FAIL stream1_stall_len: emit cycles %0d required %0d", cyc, NST + 2);
        end
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (d4 !== 1'b0 || v4 !== 1'b0) begin
        errors++; $display("FAIL stream%0d_idle: done=%b valid=%b required 0 0", mode, d4, v4);
      end
      repeat (3) tick();
    end
  endtask

  task automatic test_rst_mid;
    init_a = '0; init_b = '0; init_ph = 2'b00;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (v4 !== 1'b0 || b4 !== 1'b0 || d4 !== 1'b0 || s4 !== '0) begin
      errors++;
      $display("FAIL rst_mid: valid=%b busy=%b done=%b state=%h required 0 0 0 00", v4, b4, d4, s4);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (d4 !== 1'b0 || v4 !== 1'b0) begin
        errors++; $display("FAIL rst_no_done cyc %0d: done=%b valid=%b required 0 0", i, d4, v4);
      end
      tick();
    end
  endtask

  task automatic test_steps1;
    int a, b, p, na, nb, np;
`ifdef DPF_TRACE_GEN_INIT_CHECK_EN
    a = 0; b = 0; p = 0;
`else
    a = $urandom_range(MOD - 1); b = $urandom_range(MOD - 1); p = $urandom_range(3);
`endif
    succ(a, b, p, na, nb, np);
    init_a = CW'(a); init_b = CW'(b); init_ph = 2'(p);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (v1 !== 1'b1 || s1 !== pack(a, b, p) || n1 !== pack(na, nb, np)) begin
      errors++;
      $display("FAIL steps1_beat: valid=%b pair %h->%h required 1 %h->%h", v1, s1, n1,
               pack(a, b, p), pack(na, nb, np));
    end
    tick();
    checks++;
    if (d1 !== 1'b1 || v1 !== 1'b0 || s1 !== pack(na, nb, np)) begin
      errors++;
      $display("FAIL steps1_done: done=%b valid=%b state=%h required 1 0 %h", d1, v1, s1, pack(na, nb, np));
    end
    tick();
    checks++;
    if (d1 !== 1'b0) begin
      errors++; $display("FAIL steps1_done_len: done=%b required 0", d1);
    end
    repeat (8) tick();
  endtask

`ifdef DPF_TRACE_GEN_INIT_CHECK_EN
  task automatic test_init_check;
    init_a = 3'd3; init_b = '0; init_ph = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (e4 !== 1'b1 || v4 !== 1'b0) begin
      errors++; $display("FAIL init_reject: err=%b valid=%b required 1 0", e4, v4);
    end
    tick();
    checks++;
    if (e4 !== 1'b0 || v4 !== 1'b0) begin
      errors++; $display("FAIL init_reject_len: err=%b valid=%b required 0 0", e4, v4);
    end
    init_a = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (v4 !== 1'b1 || e4 !== 1'b0 || s4 !== '0) begin
      errors++; $display("FAIL init_accept: valid=%b err=%b state=%h required 1 0 00", v4, e4, s4);
    end
    repeat (10) tick();
  endtask
`else
  task automatic test_err_tied;
    init_a = 3'd3; init_b = 3'd5; init_ph = 2'b10;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (e4 !== 1'b0 || v4 !== 1'b1 || s4 !== pack(3, 5, 2)) begin
      errors++;
      $display("FAIL err_tied: err=%b valid=%b state=%h required 0 1 %h", e4, v4, s4, pack(3, 5, 2));
    end
    repeat (10) tick();
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
`ifndef DPF_TRACE_GEN_INIT_CHECK_EN
    test_wrap();
`endif
    test_random_stream(0, 12);
    test_random_stream(1, 2);
    test_random_stream(2, 3);
    test_rst_mid();
    test_steps1();
`ifdef DPF_TRACE_GEN_INIT_CHECK_EN
    test_init_check();
`else
    test_err_tied();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dpf_trace_gen.md
# dpf_trace_gen

Sequential generator for the small dynamic-partition fixpoint transition system. It steps two modulo-2^CNT_W counters and a 2-bit Johnson phase register and emits one (current, next) state pair per accepted beat on a valid/ready stream. It is the producing end of the combinational transition/fixpoint checker. That checker consumes exactly these pairs, so the block drives the checker's current-state and next-state vectors in simulation and on FPGA bring-up.

## Interface
- CNT_W, 3: width of each counter (A and B).
- STEPS, 16: number of transitions emitted per run; legal range 1..65535.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- init_a  in  CNT_W  initial counter A.
- init_b  in  CNT_W  initial counter B.
- init_ph  in  2  initial phase.
- out_valid  out  1  beat available.
- out_ready  in  1  downstream accepts beat.
- out_state  out  2*CNT_W+2  current state, packed as follows:
  - [CNT_W-1:0] = A
  - [2*CNT_W-1:CNT_W] = B
  - [2*CNT_W+1:2*CNT_W] = ph
- out_next  out  2*CNT_W+2  successor of out_state, same packing.
- busy  out  1  high in EMIT.
- done  out  1  one-cycle pulse at run completion.
- err  out  1  one-cycle pulse on a rejected start (only with the macro defined).

## Operation
- Transition function:
  - mode = ph[1] ^ ph[0].
  - mode 0: A' = A+1 mod 2^CNT_W, B' = B.
  - mode 1: B' = B+1 mod 2^CNT_W, A' = A.
  - ph'[0] = ~ph[1], ph'[1] = ph[0].
  - Phase cycles 00→01→11→10→00, with modes 0,1,0,1; A and B therefore advance alternately.
- out_next is combinational from the registered state. out_state and out_next are always a legal pair.
- FSM states and transitions:
  - IDLE: out_valid=0. On start, load state from init_*, clear the step counter (16 bits), go to EMIT.
  - EMIT: out_valid=1. On a handshake (out_valid & out_ready), state <= out_next and step <= step+1. If the step count was STEPS-1, go to DONE instead.
  - DONE: done=1 for exactly one cycle, then IDLE. The final state is held on out_state, with out_valid=0.
- start is ignored outside IDLE.
- Counter wrap is silent: A=2^CNT_W-1 in mode 0 goes to 0, with no flag.

## Timing
- Reset values: out_valid=0, busy=0, done=0, err=0, out_state=0, out_next = successor of all-zero (A=1, B=0, ph=01). FSM goes to IDLE and the step counter to 0.
- start sampled at edge t: out_valid=1 and busy=1 from cycle t+1. Latency is 1 cycle.
- With out_ready held high, one beat per cycle. The STEPS beats occupy cycles t+1..t+STEPS, and done is high in cycle t+STEPS+1.
- While out_valid=1 and out_ready=0, out_state and out_next are held stable. out_valid never deasserts without a handshake.
- rst mid-run takes effect at the next edge. It overrides start and handshake in the same cycle, and no done pulse is produced.
- STEPS=1: a single beat, then DONE.

## Configuration
- DPF_TRACE_GEN_INIT_CHECK_EN defined:
  - start is accepted only if init_a, init_b and init_ph are all zero. This is the checker's initial-state antecedent.
  - Otherwise err pulses in the cycle after start and the FSM stays in IDLE.
- Undefined:
  - Any init value is accepted.
  - err is tied 0.

## Test plan
- Reset, then start with init 0/0/00, STEPS=4, out_ready=1. Beats (A,B,ph)→next must be:
  - (0,0,00)→(1,0,01)
  - (1,0,01)→(1,1,11)
  - (1,1,11)→(2,1,10)
  - (2,1,10)→(2,2,00)
  - then done pulses once in the following cycle.
- Wrap: init A=7, B=7, ph=00, STEPS=2 → beats (7,7,00)→(0,7,01) and (0,7,01)→(0,0,11).
- Backpressure: toggle out_ready 1,0,0,1 during the run → the held beat is unchanged while stalled, there are exactly STEPS handshakes, and done is delayed by 2 cycles.
- start asserted during EMIT → ignored, and the beat sequence is unaltered. rst asserted after the 2nd beat → out_valid=0, busy=0 next cycle, no done.
- With DPF_TRACE_GEN_INIT_CHECK_EN: start with init_a=3 → err=1 for one cycle, out_valid stays 0. A subsequent zero-init start runs normally.
